// File: rtl/event_tx_fifo.sv
// event_tx_fifo: buffers filtered spike events and presents them one at a time on a valid/ack handshake.
// Optional EVENT_TX_COALESCE_EN merges a repeated (x,y) into the newest still-queued entry.
module event_tx_fifo #(
  parameter int COORD_BITS  = 8,
  parameter int IN_CHANNELS = 4,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16,
  parameter int FIFO_DEPTH  = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COORD_BITS-1:0]  in_x,
  input  logic [COORD_BITS-1:0]  in_y,
  input  logic [IN_CHANNELS-1:0] in_spikes,
  output logic [COORD_BITS-1:0]  event_out_x,
  output logic [COORD_BITS-1:0]  event_out_y,
  output logic [IN_CHANNELS-1:0] event_out_spikes,
  output logic                   event_valid,
  input  logic                   event_ack,
  output logic [CW-1:0]          fifo_count,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  input  logic                   clr_stats
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam logic [COORD_BITS:0] W_LIM = (COORD_BITS+1)'(IMG_WIDTH);
  localparam logic [COORD_BITS:0] H_LIM = (COORD_BITS+1)'(IMG_HEIGHT);
  logic [COORD_BITS-1:0]  r_mem_x [FIFO_DEPTH];
  logic [COORD_BITS-1:0]  r_mem_y [FIFO_DEPTH];
  logic [IN_CHANNELS-1:0] r_mem_s [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [COORD_BITS-1:0]  r_out_x, r_out_y;
  logic [IN_CHANNELS-1:0] r_out_s;
  logic                   r_ovf;
  logic [15:0]            r_drop;
  state_t                 r_state, w_next;
  logic w_full, w_in_range, w_nz, w_accept, w_coalesce, w_push, w_pop, w_load, w_drop, w_full_drop;
  assign w_full      = r_count == CW'(FIFO_DEPTH);
  assign w_in_range  = ({1'b0, in_x} < W_LIM) && ({1'b0, in_y} < H_LIM);
  assign w_nz        = |in_spikes;
  assign w_accept    = in_valid && !w_full && w_nz && w_in_range;
  assign w_full_drop = in_valid && w_nz && w_full;
  assign w_drop      = in_valid && w_nz && (w_full || !w_in_range);
`ifdef EVENT_TX_COALESCE_EN
  logic [AW-1:0] w_last;
  assign w_last = r_wr_ptr - 1'b1;
  // The head is untouchable outside GAP: it is either being loaded or already presented.
  assign w_coalesce = w_accept && r_count != '0 && r_mem_x[w_last] == in_x &&
                      r_mem_y[w_last] == in_y && !(w_last == r_rd_ptr && r_state != GAP);
`else
  assign w_coalesce = 1'b0;
`endif
  assign w_push = w_accept && !w_coalesce;
  always_comb begin
    w_load = r_state == IDLE && r_count != '0;
    w_pop  = r_state == SEND && event_ack;
    w_next = w_load ? SEND : w_pop ? GAP : r_state == GAP ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_out_x  <= '0;
      r_out_y  <= '0;
      r_out_s  <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_state  <= w_next;
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_load) begin
        r_out_x <= r_mem_x[r_rd_ptr];
        r_out_y <= r_mem_y[r_rd_ptr];
        r_out_s <= r_mem_s[r_rd_ptr];
      end
      r_ovf  <= clr_stats ? 1'b0 : r_ovf | w_full_drop;
      r_drop <= clr_stats ? '0 : (w_drop && r_drop != '1) ? r_drop + 16'd1 : r_drop;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr] <= in_x;
      r_mem_y[r_wr_ptr] <= in_y;
      r_mem_s[r_wr_ptr] <= in_spikes;
    end
`ifdef EVENT_TX_COALESCE_EN
    if (w_coalesce) r_mem_s[w_last] <= r_mem_s[w_last] | in_spikes;
`endif
  end
  assign in_ready         = !w_full;
  assign event_valid      = r_state == SEND;
  assign event_out_x      = r_out_x;
  assign event_out_y      = r_out_y;
  assign event_out_spikes = r_out_s;
  assign fifo_count       = r_count;
  assign overflow         = r_ovf;
  assign drop_count       = r_drop;
endmodule

// File: tb/tb_event_tx_fifo.sv
// tb_event_tx_fifo: queue-based reference model compared every cycle, plus directed literal checks.
module tb_event_tx_fifo;
  localparam int D = 8;
  localparam int W = 16;
  localparam int H = 16;
  typedef struct packed {logic [7:0] x; logic [7:0] y; logic [3:0] s;} ev_t;
  logic clk = 0, rst_n = 0, in_valid = 0, event_ack = 0, clr_stats = 0;
  logic [7:0] in_x = 0, in_y = 0;
  logic [3:0] in_spikes = 0;
  logic in_ready, event_valid, overflow;
  logic [7:0] event_out_x, event_out_y;
  logic [3:0] event_out_spikes;
  logic [3:0] fifo_count;
  logic [15:0] drop_count;
  int tests = 0, fails = 0;
  event_tx_fifo #(.COORD_BITS(8), .IN_CHANNELS(4), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_spikes(in_spikes), .event_out_x(event_out_x), .event_out_y(event_out_y),
    .event_out_spikes(event_out_spikes), .event_valid(event_valid), .event_ack(event_ack),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count), .clr_stats(clr_stats));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: queue holds every buffered entry; the presented one leaves on ack.
  ev_t q[$];
  ev_t m_out;
  int m_phase;
  bit m_ovf;
  logic [15:0] m_drops;
  always @(posedge clk) begin : model
    int n, ph;
    bit pop, full, locked;
    if (!rst_n) begin
      q.delete(); m_out = '0; m_phase = 0; m_ovf = 0; m_drops = 0;
    end else begin
      n = q.size(); ph = m_phase; full = n == D;
      pop = ph == 1 && event_ack;
      locked = n == 1 && ph != 2;
      if (ph == 0 && n > 0) begin m_out = q[0]; m_phase = 1; end
      else if (pop) m_phase = 2;
      else if (ph == 2) m_phase = 0;
      if (in_valid && in_spikes != 0) begin
        if (full || in_x >= W || in_y >= H) begin
          if (full) m_ovf = 1;
          if (m_drops != 16'hFFFF) m_drops++;
        end
`ifdef EVENT_TX_COALESCE_EN
        else if (n > 0 && q[n-1].x == in_x && q[n-1].y == in_y && !locked) q[n-1].s = q[n-1].s | in_spikes;
`endif
        else q.push_back('{x: in_x, y: in_y, s: in_spikes});
      end
      if (pop) void'(q.pop_front());
      if (clr_stats) begin m_drops = 0; m_ovf = 0; end
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("in_ready", in_ready, q.size() < D);
    chk("event_valid", event_valid, m_phase == 1);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
    chk("out_x", event_out_x, m_out.x);
    chk("out_y", event_out_y, m_out.y);
    chk("out_s", event_out_spikes, m_out.s);
  end
  task automatic step(); @(negedge clk); #1; endtask
  task automatic wr(input int x, input int y, input int s);
    in_valid = 1; in_x = 8'(x); in_y = 8'(y); in_spikes = 4'(s);
    step();
    in_valid = 0;
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 20 && !event_valid; i++) step();
    chk("wait_valid", event_valid, 1);
  endtask
  task automatic ack_one(); event_ack = 1; step(); event_ack = 0; endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", event_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drops", drop_count, 0);
    // single event, ack one cycle after valid
    wr(3, 4, 5);
    chk("t1_count", fifo_count, 1);
    chk("t1_valid_early", event_valid, 0);
    step();
    chk("t1_valid", event_valid, 1);
    chk("t1_data", {event_out_x, event_out_y, event_out_spikes}, {8'd3, 8'd4, 4'd5});
    ack_one();
    chk("t1_gap", event_valid, 0);
    chk("t1_count0", fifo_count, 0);
    step();
    // fill past depth without ack, then drain in order
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_x = 8'(i); in_y = 8'(i + 1); in_spikes = 4'(i + 1);
      step();
    end
    in_valid = 0;
    chk("t2_ready", in_ready, 0);
    chk("t2_ovf", overflow, 1);
    chk("t2_drops", drop_count, 1);
    chk("t2_count", fifo_count, 8);
    for (int i = 0; i < 8; i++) begin
      wait_valid();
      chk("t2_order_x", event_out_x, i);
      chk("t2_order_s", event_out_spikes, i + 1);
      ack_one();
    end
    chk("t2_empty", fifo_count, 0);
    // filtering
    clr_stats = 1; step(); clr_stats = 0;
    chk("t3_clr", drop_count, 0);
    wr(1, 1, 0);
    chk("t3_zero_count", fifo_count, 0);
    chk("t3_zero_drops", drop_count, 0);
    wr(W, 1, 1);
    chk("t3_x_oor", drop_count, 1);
    wr(2, H, 1);
    chk("t3_y_oor", drop_count, 2);
    chk("t3_count", fifo_count, 0);
    // long hold in SEND and stray acks in GAP/IDLE
    wr(7, 2, 3);
    wr(9, 8, 6);
    wait_valid();
    repeat (20) step();
    chk("t4_hold_valid", event_valid, 1);
    chk("t4_hold_data", {event_out_x, event_out_y, event_out_spikes}, {8'd7, 8'd2, 4'd3});
    ack_one();
    chk("t4_gap", event_valid, 0);
    event_ack = 1; step(); step(); event_ack = 0;
    chk("t4_no_pop", fifo_count, 1);
    chk("t4_next", event_out_x, 9);
    ack_one();
    repeat (2) step();
    // full + simultaneous ack and input; clr_stats beats a drop
    for (int i = 0; i < 8; i++) wr(i + 1, 3, 1);
    chk("t5_full", fifo_count, 8);
    wait_valid();
    in_valid = 1; in_x = 10; in_y = 10; in_spikes = 1; event_ack = 1;
    step();
    in_valid = 0; event_ack = 0;
    chk("t5_ovf", overflow, 1);
    chk("t5_count", fifo_count, 7);
    chk("t5_drops", drop_count, 3);
    in_valid = 1; in_x = 20; clr_stats = 1;
    step();
    in_valid = 0; clr_stats = 0;
    chk("t5_clr_drops", drop_count, 0);
    chk("t5_clr_ovf", overflow, 0);
    for (int i = 0; i < 7; i++) begin wait_valid(); ack_one(); end
    chk("t5_empty", fifo_count, 0);
    // asynchronous reset mid-presentation
    wr(4, 4, 1);
    wait_valid();
    rst_n = 0;
    #1 chk("t6_async_valid", event_valid, 0);
    chk("t6_async_count", fifo_count, 0);
    step();
    rst_n = 1;
    chk("t6_after_valid", event_valid, 0);
    chk("t6_after_count", fifo_count, 0);
`ifdef EVENT_TX_COALESCE_EN
    wr(1, 1, 8);
    wait_valid();
    wr(5, 5, 1);
    wr(5, 5, 1);
    chk("t7_one_entry", fifo_count, 2);
    wr(5, 5, 2);
    chk("t7_count", fifo_count, 2);
    ack_one();
    wait_valid();
    chk("t7_merged", {event_out_x, event_out_y, event_out_spikes}, {8'd5, 8'd5, 4'd3});
    ack_one();
`endif
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
